// File: rtl/gppcu_seq_pkg.sv
// gppcu_seq_pkg
// Shared definitions for the GPPCU instruction sequencer:
//   - default widths (instruction word, instruction address, program length)
//   - default pipeline drain depth
//   - sequencer state encoding
package gppcu_seq_pkg;

  localparam int DBW_DEF          = 32;
  localparam int IABW_DEF         = 10;
  localparam int LENW_DEF         = 11;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/gppcu_seq_skid_fifo.sv
// gppcu_seq_skid_fifo
// Two-entry FIFO buffering instruction words between the instruction RAM
// and the core port.
//   clk_i, rst_i   clock, asynchronous active-high reset (pointers/count only)
//   push_i/wdata_i write one word
//   pop_i          remove head word
//   flush_i        empty the FIFO (wins over push and pop)
//   count_o        occupancy 0..2
//   head_o         oldest word (meaningful only when count_o != 0)
module gppcu_seq_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push_i) wptr_d = ~wptr_q;
      if (pop_i)  rptr_d = ~rptr_q;
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is data-path only and carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/gppcu_instr_sequencer.sv
// gppcu_instr_sequencer
// Streams a block of instructions from instruction RAM into the core's
// valid/ready instruction port, then waits for the core pipeline to drain
// before pulsing oDONE.
//   iACLK/iRST              clock, asynchronous active-high reset
//   iSTART/iBASE_ADDR/iLENGTH  run request (sampled in IDLE only)
//   iABORT                  stop issuing, flush, drain (FETCH only)
//   oBUSY/oDONE             run status
//   oIMEM_ADDR/oIMEM_RD     RAM read port, data on iIMEM_RDATA next cycle
//   oINSTR/oINSTR_VALID/iINSTR_READY  core instruction handshake
//   iCORE_BUSY              holds the drain countdown
//   oISSUED_CNT             instructions accepted in current run
// Optional build macro GPPCU_SEQ_PERF_CNT_EN adds oCYCLE_CNT (busy cycles)
// and oSTALL_CNT (valid-but-not-ready cycles).
module gppcu_instr_sequencer
  import gppcu_seq_pkg::*;
#(
  parameter int DBW          = DBW_DEF,
  parameter int IABW         = IABW_DEF,
  parameter int LENW         = LENW_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic            iACLK,
  input  logic            iRST,
  input  logic            iSTART,
  input  logic [IABW-1:0] iBASE_ADDR,
  input  logic [LENW-1:0] iLENGTH,
  input  logic            iABORT,
  output logic            oBUSY,
  output logic            oDONE,
  output logic [IABW-1:0] oIMEM_ADDR,
  output logic            oIMEM_RD,
  input  logic [DBW-1:0]  iIMEM_RDATA,
  output logic [DBW-1:0]  oINSTR,
  output logic            oINSTR_VALID,
  input  logic            iINSTR_READY,
  input  logic            iCORE_BUSY,
  output logic [LENW-1:0] oISSUED_CNT
`ifdef GPPCU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     oCYCLE_CNT,
  output logic [31:0]     oSTALL_CNT
`endif
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 2);

  seq_state_e      state_q, state_d;
  logic [IABW-1:0] base_q, base_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] rd_cnt_q, rd_cnt_d;
  logic [LENW-1:0] iss_q, iss_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            rd_pend_q;

  logic [1:0]      fifo_cnt;
  logic [DBW-1:0]  fifo_head;
  logic            in_fetch, abort_now, valid, xfer, push, rd, start_ok;
  logic [2:0]      occ;

  assign in_fetch  = (state_q == ST_FETCH);
  assign abort_now = in_fetch & iABORT;
  assign start_ok  = (state_q == ST_IDLE) & iSTART;
  assign valid     = (fifo_cnt != 2'd0);
  assign xfer      = valid & iINSTR_READY;
  // A read returning during an abort cycle is the in-flight result to drop.
  assign push      = rd_pend_q & in_fetch & ~abort_now;

  // Buffer slots committed (stored + in flight), net of a same-cycle pop, so
  // a word leaving this cycle frees its slot immediately and back-to-back
  // transfers are sustained with ready held high.
  assign occ = {1'b0, fifo_cnt} + {2'b00, rd_pend_q} - {2'b00, xfer};
  assign rd  = in_fetch & ~iABORT & (rd_cnt_q < len_q) & (occ < 3'd2);

  gppcu_seq_skid_fifo #(
    .DATA_W(DBW)
  ) u_fifo (
    .clk_i   (iACLK),
    .rst_i   (iRST),
    .push_i  (push),
    .wdata_i (iIMEM_RDATA),
    .pop_i   (xfer),
    .flush_i (abort_now),
    .count_o (fifo_cnt),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    iss_d    = iss_q;
    drain_d  = drain_q;
    if (xfer) iss_d    = iss_q + LENW'(1);
    if (rd)   rd_cnt_d = rd_cnt_q + LENW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          base_d   = iBASE_ADDR;
          len_d    = iLENGTH;
          rd_cnt_d = '0;
          iss_d    = '0;
          state_d  = (iLENGTH == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (iABORT || (iss_d == len_q)) begin
          state_d = ST_DRAIN;
          drain_d = DCW'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        // Countdown only advances while the core's multi-cycle unit is idle.
        if (!iCORE_BUSY) begin
          if (drain_q <= DCW'(1)) begin
            drain_d = '0;
            state_d = ST_DONE;
          end else begin
            drain_d = drain_q - DCW'(1);
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iACLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      iss_q     <= '0;
      drain_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      iss_q     <= iss_d;
      drain_q   <= drain_d;
      rd_pend_q <= rd;
    end
  end

  assign oBUSY        = (state_q != ST_IDLE);
  assign oDONE        = (state_q == ST_DONE);
  assign oIMEM_RD     = rd;
  assign oIMEM_ADDR   = base_q + rd_cnt_q[IABW-1:0];
  assign oINSTR_VALID = valid;
  // Unreset buffer storage is masked so the port reads zero while empty.
  assign oINSTR       = valid ? fifo_head : '0;
  assign oISSUED_CNT  = iss_q;

`ifdef GPPCU_SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d, stall_q, stall_d;

  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if (start_ok) begin
      cyc_d   = '0;
      stall_d = '0;
    end else begin
      if (oBUSY)                 cyc_d   = cyc_q + 32'd1;
      if (valid && !iINSTR_READY) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge iACLK or posedge iRST) begin
    if (iRST) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign oCYCLE_CNT = cyc_q;
  assign oSTALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_gppcu_instr_sequencer.sv
`timescale 1ns/1ps
module tb_gppcu_instr_sequencer;

  localparam int DBW   = 32;
  localparam int IABW  = 10;
  localparam int LENW  = 11;
  localparam int DRAIN = 4;
  localparam int MAXC  = 200;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0, abort = 1'b0, ready = 1'b0, cbusy = 1'b0;
  logic [IABW-1:0] base = '0;
  logic [LENW-1:0] len = '0;
  logic            busy_o, done_o, rd_o, valid_o;
  logic [IABW-1:0] addr_o;
  logic [DBW-1:0]  rdata = '0;
  logic [DBW-1:0]  instr_o;
  logic [LENW-1:0] issued_o;
`ifdef GPPCU_SEQ_PERF_CNT_EN
  logic [31:0]     cyc_o, stall_o;
`endif

  always #5 clk = ~clk;

  gppcu_instr_sequencer dut (
    .iACLK        (clk),
    .iRST         (rst),
    .iSTART       (start),
    .iBASE_ADDR   (base),
    .iLENGTH      (len),
    .iABORT       (abort),
    .oBUSY        (busy_o),
    .oDONE        (done_o),
    .oIMEM_ADDR   (addr_o),
    .oIMEM_RD     (rd_o),
    .iIMEM_RDATA  (rdata),
    .oINSTR       (instr_o),
    .oINSTR_VALID (valid_o),
    .iINSTR_READY (ready),
    .iCORE_BUSY   (cbusy),
    .oISSUED_CNT  (issued_o)
`ifdef GPPCU_SEQ_PERF_CNT_EN
    ,
    .oCYCLE_CNT   (cyc_o),
    .oSTALL_CNT   (stall_o)
`endif
  );

  // Instruction RAM: every address holds a word that encodes the address.
  function automatic logic [DBW-1:0] word_of(input logic [IABW-1:0] a);
    return {16'hC0DE, 6'h2A, a};
  endfunction

  always @(posedge clk) if (rd_o) rdata <= word_of(addr_o);

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Per-run stimulus, indexed by cycle (cycle 0 = start cycle).
  bit              rdy_a [MAXC];
  bit              abt_a [MAXC];
  bit              cb_a  [MAXC];
  bit              st_a  [MAXC];
  logic [IABW-1:0] jb_a  [MAXC];
  logic [LENW-1:0] jl_a  [MAXC];

  // Observations of the last run.
  int     obs_done, obs_reads, obs_first;
  longint obs_issued;
  int     m_busy, m_stall;

  // Run one program and compare every cycle against a count-based model:
  //  - a word read at cycle k is presentable from cycle k+2
  //  - a read is allowed while fewer than 2 words are held/in flight
  //    (a word leaving this cycle no longer counts)
  //  - run ends when transfers reach the length or an abort is seen;
  //    then DRAIN non-busy cycles, then one DONE cycle.
  task automatic run(input logic [IABW-1:0] b, input int l);
    int phase;   // 0 idle, 1 fetch, 2 drain, 3 done
    int reads_m, arrived_m, xfers_m, cnt_m;
    bit finished;
    bit v_m, x_m, r_m;
    logic [IABW-1:0] a_m;
    bit rd_hist [MAXC];
    phase = 0; reads_m = 0; arrived_m = 0; xfers_m = 0; cnt_m = 0;
    finished = 1'b0;
    m_busy = 0; m_stall = 0;
    obs_done = -1; obs_reads = 0; obs_first = -1; obs_issued = -1;
    for (int k = 0; k < MAXC; k++) rd_hist[k] = 1'b0;
    for (int k = 0; k < MAXC && !finished; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b1; base = b; len = LENW'(l);
      end else begin
        start = st_a[k]; base = jb_a[k]; len = jl_a[k];
      end
      ready = rdy_a[k]; abort = abt_a[k]; cbusy = cb_a[k];
      #1;
      if (k >= 2 && rd_hist[k-2]) arrived_m++;
      v_m = (phase == 1) && (arrived_m > xfers_m);
      x_m = v_m && ready;
      r_m = (phase == 1) && !abort && (reads_m < l) && ((reads_m - xfers_m - int'(x_m)) < 2);
      a_m = IABW'(int'(b) + reads_m);
      chk($sformatf("c%0d_busy", k), busy_o, (phase != 0));
      chk($sformatf("c%0d_done", k), done_o, (phase == 3));
      chk($sformatf("c%0d_valid", k), valid_o, v_m);
      if (v_m) chk($sformatf("c%0d_instr", k), instr_o, word_of(IABW'(int'(b) + xfers_m)));
      if (!(phase == 1 && abort)) chk($sformatf("c%0d_rd", k), rd_o, r_m);
      if (r_m) chk($sformatf("c%0d_addr", k), addr_o, a_m);
      if (k > 0) chk($sformatf("c%0d_issued", k), issued_o, xfers_m);
      if (rd_o) obs_reads++;
      if (valid_o && obs_first < 0) obs_first = k;
      if (done_o && obs_done < 0) begin
        obs_done = k; obs_issued = issued_o;
      end
      if (phase != 0) m_busy++;
      if (v_m && !ready) m_stall++;
      rd_hist[k] = r_m;
      if (x_m) xfers_m++;
      if (r_m) reads_m++;
      case (phase)
        0: phase = (l == 0) ? 3 : 1;
        1: if (abort || xfers_m == l) begin phase = 2; cnt_m = DRAIN; end
        2: if (!cbusy) begin cnt_m--; if (cnt_m == 0) phase = 3; end
        default: begin phase = 0; finished = 1'b1; end
      endcase
    end
    if (!finished) chk("run_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0; ready = 1'b1; cbusy = 1'b0;
    #1;
    chk("idle_busy", busy_o, 0);
`ifdef GPPCU_SEQ_PERF_CNT_EN
    chk("perf_cycles", cyc_o, m_busy);
    chk("perf_stalls", stall_o, m_stall);
`endif
  endtask

  typedef struct {
    logic [IABW-1:0] base;
    int len;
    int rlo_from, rlo_len;
    int abort_at;
    int cb_from, cb_len;
    int exp_issued, exp_done, exp_reads, exp_first;
  } vec_t;

  task automatic set_stim(input vec_t v);
    for (int k = 0; k < MAXC; k++) begin
      rdy_a[k] = !(k >= v.rlo_from && k < v.rlo_from + v.rlo_len);
      abt_a[k] = (k == v.abort_at);
      cb_a[k]  = (k >= v.cb_from && k < v.cb_from + v.cb_len);
      st_a[k]  = 1'b0;
      jb_a[k]  = ~v.base;
      jl_a[k]  = LENW'(5);
    end
  endtask

  initial begin
    vec_t tv [6];
    vec_t rv;
    bit   saw_done;
    //          base     len rlo     abort cb      iss done reads first
    tv[0] = '{10'h3FE, 4, 0, 0,  -1, 0, 0,  4, 11,  4, 3};  // wrap, full rate
    tv[1] = '{10'h100, 3, 3, 5,  -1, 0, 0,  3, 15,  3, 3};  // 5-cycle stall
    tv[2] = '{10'h055, 0, 0, 0,  -1, 0, 0,  0,  1,  0, -1}; // empty program
    tv[3] = '{10'h200, 8, 0, 0,   5, 0, 0,  3, 10, -1, 3};  // abort w/ transfer
    tv[4] = '{10'h010, 2, 0, 0,  -1, 5, 6,  2, 15,  2, 3};  // core busy in drain
    tv[5] = '{10'h010, 2, 0, 0,  -1, 0, 0,  2,  9,  2, 3};  // same, no busy

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_issued", issued_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      set_stim(tv[i]);
      run(tv[i].base, tv[i].len);
      chk($sformatf("vec%0d_issued", i), obs_issued, tv[i].exp_issued);
      chk($sformatf("vec%0d_done_cyc", i), obs_done, tv[i].exp_done);
      if (tv[i].exp_reads >= 0) chk($sformatf("vec%0d_reads", i), obs_reads, tv[i].exp_reads);
      chk($sformatf("vec%0d_first_valid", i), obs_first, tv[i].exp_first);
    end

    // Reset in the middle of FETCH
    @(negedge clk);
    start = 1'b1; base = '0; len = LENW'(8); ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rd", rd_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_instr", instr_o, 0);
    chk("midrst_issued", issued_o, 0);
    chk("midrst_addr", addr_o, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (done_o || busy_o) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);

    // Restart with 3 injected stall cycles
    rv = '{10'h0A0, 2, 3, 3, -1, 0, 0, 2, 12, 2, 3};
    set_stim(rv);
    run(rv.base, rv.len);
    chk("restart_issued", obs_issued, 2);
    chk("restart_done_cyc", obs_done, 12);
`ifdef GPPCU_SEQ_PERF_CNT_EN
    chk("restart_stall_cnt", stall_o, 3);
`endif

    // Randomized runs: stalls, core busy, stray starts/aborts
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < MAXC; k++) begin
        rdy_a[k] = (k >= 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
        cb_a[k]  = (k >= 150) ? 1'b0 : ($urandom_range(0, 3) == 0);
        abt_a[k] = (k >= 150) ? 1'b0 : ($urandom_range(0, 39) == 0);
        st_a[k]  = ($urandom_range(0, 7) == 0);
        jb_a[k]  = IABW'($urandom_range(0, 1023));
        jl_a[k]  = LENW'($urandom_range(0, 2047));
      end
      run(IABW'($urandom_range(0, 1023)), $urandom_range(0, 12));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
